// File: rtl/bnb_vector_sequencer.sv
// ============================================================================
// Module      : bnb_vector_sequencer
// Description : Clocked stimulus sequencer for one blocking/non-blocking
//               comparison datapath. On an accepted start it walks {a,b,c,d}
//               through vectors 0..NUM_VEC-1. Each vector is held for
//               HOLD_CYCLES drive cycles plus one sample cycle. In the sample
//               cycle f_b and f_nb are compared, and differing cycles are
//               counted into a saturating counter. A normal finish raises a
//               one-cycle done pulse.
// Ports       : clk, rst (async, active-high)
//               start, abort            host control inputs
//               busy, done              host status outputs
//               a, b, c, d              datapath stimulus (registered)
//               f_b, f_nb               datapath results (sampled)
//               vec_idx[3:0]            current / last vector index
//               mismatch_cnt[CNT_W-1:0] saturating mismatch count
//               first_mm_vec[3:0],
//               first_mm_valid          only when BNB_FIRST_MISMATCH_EN is
//                                       defined: index of the first counted
//                                       mismatch of the run
// Config      : `define BNB_FIRST_MISMATCH_EN adds the first-mismatch capture
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module bnb_vector_sequencer #(
  parameter int NUM_VEC     = 16,
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  input  logic             f_b,
  input  logic             f_nb,
  output logic [3:0]       vec_idx,
`ifdef BNB_FIRST_MISMATCH_EN
  output logic [3:0]       first_mm_vec,
  output logic             first_mm_valid,
`endif
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam int               HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [3:0]       LAST_VEC  = 4'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state;
  logic [HC_W-1:0] hold_cnt;
  logic [3:0]      next_vec;

  assign next_vec = vec_idx + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      hold_cnt       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      {a, b, c, d}   <= 4'd0;
      vec_idx        <= 4'd0;
      mismatch_cnt   <= '0;
`ifdef BNB_FIRST_MISMATCH_EN
      first_mm_vec   <= 4'd0;
      first_mm_valid <= 1'b0;
`endif
    end else begin
      // done is a single-cycle pulse; only the SAMPLE->DONE edge raises it.
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // abort beats start in IDLE: simply stay put.
          if (start && !abort) begin
            state          <= S_DRIVE;
            busy           <= 1'b1;
            hold_cnt       <= '0;
            vec_idx        <= 4'd0;
            {a, b, c, d}   <= 4'd0;
            mismatch_cnt   <= '0;
`ifdef BNB_FIRST_MISMATCH_EN
            first_mm_vec   <= 4'd0;
            first_mm_valid <= 1'b0;
`endif
          end
        end

        S_DRIVE: begin
          if (abort) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            {a, b, c, d} <= 4'd0;
          end else if (hold_cnt == HOLD_LAST) begin
            state <= S_SAMPLE;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        S_SAMPLE: begin
          // An aborted sample cycle discards its comparison result.
          if (abort) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            {a, b, c, d} <= 4'd0;
          end else begin
            if (f_b != f_nb) begin
              if (mismatch_cnt != CNT_MAX) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
              end
`ifdef BNB_FIRST_MISMATCH_EN
              if (!first_mm_valid) begin
                first_mm_vec   <= vec_idx;
                first_mm_valid <= 1'b1;
              end
`endif
            end
            if (vec_idx == LAST_VEC) begin
              // Last vector: keep a..d and vec_idx as the run's final view.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state        <= S_DRIVE;
              hold_cnt     <= '0;
              vec_idx      <= next_vec;
              {a, b, c, d} <= next_vec;
            end
          end
        end

        S_DONE: begin
          // start is not honoured here; it must be presented in IDLE.
          state <= S_IDLE;
          if (abort) begin
            {a, b, c, d} <= 4'd0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bnb_vector_sequencer.sv
// ============================================================================
// Module      : tb_bnb_vector_sequencer
// Description : Self-checking bench for bnb_vector_sequencer. A default
//               instance is compared every cycle against a run-time model that
//               is expressed as elapsed cycles since the accepted start. Two
//               extra instances cover counter saturation (CNT_W=3) and the
//               minimum configuration (NUM_VEC=1, HOLD_CYCLES=1).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_bnb_vector_sequencer;

  localparam int N    = 16;
  localparam int H    = 2;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst    = 1'b1;
  logic start  = 1'b0;
  logic abort  = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  int   mode   = 0;   // 0: f_nb==f_b, 1: differ only at 1101, 2: always differ

  // Main instance
  logic          busy, done, a, b, c, d, f_b, f_nb;
  logic [3:0]    vec_idx;
  logic [CW-1:0] mm_cnt;
  assign f_b  = (a & b) | (c ^ d);
  assign f_nb = f_b ^ ((mode == 1 && {a, b, c, d} == 4'b1101) || mode == 2);

  // Saturation instance
  logic       busy1, done1, a1, b1, c1, d1, fb1, fnb1;
  logic [3:0] vec1;
  logic [2:0] cnt1;
  assign fb1  = a1 ^ b1 ^ c1 ^ d1;
  assign fnb1 = ~fb1;

  // Minimum-configuration instance
  logic       busy2, done2, a2, b2, c2, d2, fb2;
  logic [3:0] vec2;
  logic [4:0] cnt2;
  assign fb2 = a2 | b2 | c2 | d2;

`ifdef BNB_FIRST_MISMATCH_EN
  logic [3:0] first_vec, first_vec1, first_vec2;
  logic       first_valid, first_valid1, first_valid2;
`endif

  bnb_vector_sequencer #(.NUM_VEC(N), .HOLD_CYCLES(H), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy), .done(done), .a(a), .b(b), .c(c), .d(d),
    .f_b(f_b), .f_nb(f_nb), .vec_idx(vec_idx),
`ifdef BNB_FIRST_MISMATCH_EN
    .first_mm_vec(first_vec), .first_mm_valid(first_valid),
`endif
    .mismatch_cnt(mm_cnt)
  );

  bnb_vector_sequencer #(.NUM_VEC(16), .HOLD_CYCLES(2), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .start(start1), .abort(abort),
    .busy(busy1), .done(done1), .a(a1), .b(b1), .c(c1), .d(d1),
    .f_b(fb1), .f_nb(fnb1), .vec_idx(vec1),
`ifdef BNB_FIRST_MISMATCH_EN
    .first_mm_vec(first_vec1), .first_mm_valid(first_valid1),
`endif
    .mismatch_cnt(cnt1)
  );

  bnb_vector_sequencer #(.NUM_VEC(1), .HOLD_CYCLES(1), .CNT_W(5)) dut_min (
    .clk(clk), .rst(rst), .start(start2), .abort(abort),
    .busy(busy2), .done(done2), .a(a2), .b(b2), .c(c2), .d(d2),
    .f_b(fb2), .f_nb(fb2), .vec_idx(vec2),
`ifdef BNB_FIRST_MISMATCH_EN
    .first_mm_vec(first_vec2), .first_mm_valid(first_valid2),
`endif
    .mismatch_cnt(cnt2)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- Reference model (main instance) ----------------
  // A run is described by m_e, the number of edges since the accepted start.
  // Vector k occupies elapsed cycles k*(H+1) .. k*(H+1)+H; the last of those
  // is its sample cycle. Elapsed N*(H+1) is the done cycle.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_zero   = 1'b1;   // a..d forced to zero (after reset or abort)
  int m_e      = 0;
  int m_vec    = 0;
  int m_cnt    = 0;
  int m_first  = 0;
  bit m_fv     = 1'b0;

  function automatic bit mm_of(input int v);
    return (mode == 1 && v == 13) || mode == 2;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_done <= 1'b0; m_zero <= 1'b1; m_e <= 0;
      m_vec <= 0; m_cnt <= 0; m_first <= 0; m_fv <= 1'b0;
    end else if (abort && (m_active || m_done)) begin
      m_active <= 1'b0; m_done <= 1'b0; m_zero <= 1'b1;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_active) begin
      if ((m_e % (H + 1)) == H && mm_of(m_e / (H + 1))) begin
        if (m_cnt < CMAX) m_cnt <= m_cnt + 1;
        if (!m_fv) begin m_fv <= 1'b1; m_first <= m_e / (H + 1); end
      end
      if (m_e + 1 == N * (H + 1)) begin
        m_active <= 1'b0; m_done <= 1'b1;
      end else begin
        m_vec <= (m_e + 1) / (H + 1);
      end
      m_e <= m_e + 1;
    end else if (start && !abort) begin
      m_active <= 1'b1; m_zero <= 1'b0; m_e <= 0; m_vec <= 0;
      m_cnt <= 0; m_fv <= 1'b0; m_first <= 0;
    end
  end

  always @(negedge clk) begin
    chk("busy",   int'(busy),         int'(m_active));
    chk("done",   int'(done),         int'(m_done));
    chk("vec",    int'(vec_idx),      m_vec);
    chk("abcd",   int'({a, b, c, d}), m_zero ? 0 : m_vec);
    chk("mm_cnt", int'(mm_cnt),       m_cnt);
`ifdef BNB_FIRST_MISMATCH_EN
    chk("first_vec",   int'(first_vec),   m_first);
    chk("first_valid", int'(first_valid), int'(m_fv));
`endif
  end

  // Start a run on the main instance and count edges until done is seen.
  // Returns 80 when done never appears within the budget.
  task automatic run0(input int restart_at, input int abort_at, output int edges);
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    edges = 0;
    while (edges < 80) begin
      start = (edges == restart_at);
      abort = (edges == abort_at);
      @(posedge clk); edges++;
      @(negedge clk); start = 1'b0; abort = 1'b0;
      if (done) break;
    end
  endtask

  int e;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_vec",  int'(vec_idx), 0);
    chk("rst_cnt",  int'(mm_cnt), 0);
    rst = 1'b0;

    // Clean sweep
    mode = 0;
    run0(-1, -1, e);
    chk("sweep_done_edge", e, 48);
    chk("sweep_busy_in_done", int'(busy), 0);
    chk("sweep_vec", int'(vec_idx), 15);
    chk("sweep_abcd", int'({a, b, c, d}), 15);
    chk("sweep_cnt", int'(mm_cnt), 0);

    // start presented in the DONE cycle is ignored
    start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    chk("done_start_ignored", int'(busy), 0);

    // Single mismatch at vector 13
    mode = 1;
    run0(-1, -1, e);
    chk("one_mm_done_edge", e, 48);
    chk("one_mm_cnt", int'(mm_cnt), 1);
`ifdef BNB_FIRST_MISMATCH_EN
    chk("one_mm_first_vec", int'(first_vec), 13);
    chk("one_mm_first_valid", int'(first_valid), 1);
`endif

    // Restart request while busy is ignored
    mode = 0;
    run0(20, -1, e);
    chk("restart_ignored_edge", e, 48);

    // Abort in a DRIVE cycle: samples at edges 3,6,9 already counted
    mode = 2;
    run0(-1, 10, e);
    chk("abort_no_done", e, 80);
    chk("abort_cnt", int'(mm_cnt), 3);
    chk("abort_vec", int'(vec_idx), 3);
    chk("abort_abcd", int'({a, b, c, d}), 0);

    // Abort during the sample cycle of vector 2: that mismatch is dropped
    run0(-1, 8, e);
    chk("abort_sample_cnt", int'(mm_cnt), 2);

    // Fresh run after abort clears the count
    mode = 0;
    run0(-1, -1, e);
    chk("after_abort_edge", e, 48);
    chk("after_abort_cnt", int'(mm_cnt), 0);

    // start and abort together in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", int'(busy), 0);

    // Asynchronous reset mid-sweep
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_abcd", int'({a, b, c, d}), 0);
    chk("async_rst_vec",  int'(vec_idx), 0);
    chk("async_rst_cnt",  int'(mm_cnt), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    mode = 0;
    run0(-1, -1, e);
    chk("post_rst_edge", e, 48);

    // Saturation with a 3-bit counter, every vector mismatching
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); @(negedge clk); start1 = 1'b0;
    e = 0;
    while (e < 80 && !done1) begin
      @(posedge clk); e++; @(negedge clk);
    end
    chk("sat_done_edge", e, 48);
    chk("sat_cnt", int'(cnt1), 7);
    chk("sat_vec", int'(vec1), 15);

    // Minimum configuration
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); @(negedge clk); start2 = 1'b0;
    e = 0;
    while (e < 20 && !done2) begin
      @(posedge clk); e++; @(negedge clk);
    end
    chk("min_done_edge", e, 2);
    chk("min_busy", int'(busy2), 0);
    chk("min_cnt", int'(cnt2), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
